// File: rtl/timer_countdown.sv
// Microwave cook timer: latches M:ST BCD digits on loadn and counts them down
// to 0:00 once per second while enabled, flagging zero and pulsing done.
module timer_countdown #(
  parameter int TICKS_PER_SECOND = 100000000
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       loadn,
  input  logic       enablen,
  input  logic [3:0] units_of_seconds,
  input  logic [3:0] tens_of_seconds,
  input  logic [3:0] units_of_minutes,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       zero,
  output logic       done
);

  typedef enum logic {ZERO = 1'b0, ACTIVE = 1'b1} state_t;

  localparam int PW = (TICKS_PER_SECOND > 2) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SECOND - 1);

  state_t          state, state_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic [3:0]      ld_so, ld_st, ld_mo;
  logic [3:0]      so_nxt, st_nxt, mo_nxt;
  logic            adv, tick, last, done_nxt;

  // Out-of-range keypad digits saturate to the largest legal BCD value
  always_comb begin
    ld_so = (units_of_seconds > 4'd9) ? 4'd9 : units_of_seconds;
    ld_st = (tens_of_seconds  > 4'd5) ? 4'd5 : tens_of_seconds;
    ld_mo = (units_of_minutes > 4'd9) ? 4'd9 : units_of_minutes;
  end

  assign adv  = (state == ACTIVE) && !enablen && loadn;
  assign tick = adv && (presc == PMAX);
  assign last = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) state <= ZERO;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!loadn)
      state_nxt = ((ld_so | ld_st | ld_mo) != 4'd0) ? ACTIVE : ZERO;
    else if (tick && last)
      state_nxt = ZERO;
  end

  always_comb begin
    so_nxt   = sec_ones;
    st_nxt   = sec_tens;
    mo_nxt   = min_ones;
    done_nxt = 1'b0;
    if (!loadn) begin
      so_nxt = ld_so;
      st_nxt = ld_st;
      mo_nxt = ld_mo;
    end else if (tick) begin
      done_nxt = last;
      // BCD borrow chain; tick only fires while the count is nonzero
      if (sec_ones != 4'd0) begin
        so_nxt = sec_ones - 4'd1;
      end else begin
        so_nxt = 4'd9;
        if (sec_tens != 4'd0) begin
          st_nxt = sec_tens - 4'd1;
        end else begin
          st_nxt = 4'd5;
          mo_nxt = min_ones - 4'd1;
        end
      end
    end

    if (!loadn || state == ZERO) presc_nxt = '0;
    else if (adv)                presc_nxt = (presc == PMAX) ? '0 : presc + 1'b1;
    else                         presc_nxt = presc;

    zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (min_ones == 4'd0);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      presc    <= '0;
      done     <= 1'b0;
    end else begin
      sec_ones <= so_nxt;
      sec_tens <= st_nxt;
      min_ones <= mo_nxt;
      presc    <= presc_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_timer_countdown.sv
// Bench for timer_countdown: directed scenarios followed by random traffic,
// all compared against a seconds-count reference model.
module tb_timer_countdown;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       loadn = 1'b1;
  logic       enablen = 1'b1;
  logic [3:0] units_of_seconds = 4'd0;
  logic [3:0] tens_of_seconds = 4'd0;
  logic [3:0] units_of_minutes = 4'd0;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       zero, done;

  int total = 0;
  int passed = 0;
  int fails = 0;

  // Reference: total remaining seconds, phase within the current second
  int m_sec = 0;
  int m_ph = 0;
  bit m_done = 1'b0;

  timer_countdown #(.TICKS_PER_SECOND(T)) dut (
    .clk(clk), .clearn(clearn), .loadn(loadn), .enablen(enablen),
    .units_of_seconds(units_of_seconds), .tens_of_seconds(tens_of_seconds),
    .units_of_minutes(units_of_minutes),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_sec = 0; m_ph = 0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (!clearn) begin
      model_reset();
    end else if (!loadn) begin
      m_sec = clampi(int'(units_of_minutes), 9) * 60 +
              clampi(int'(tens_of_seconds), 5) * 10 +
              clampi(int'(units_of_seconds), 9);
      m_ph = 0;
    end else if (m_sec > 0 && !enablen) begin
      if (m_ph == T - 1) begin
        m_ph = 0;
        m_sec = m_sec - 1;
        if (m_sec == 0) m_done = 1'b1;
      end else begin
        m_ph = m_ph + 1;
      end
    end
  endtask

  task automatic chk_model(input string tag);
    logic [11:0] exp;
    exp = {4'(m_sec / 60), 4'((m_sec % 60) / 10), 4'(m_sec % 10)};
    chk({tag, "_digits"}, 32'({min_ones, sec_tens, sec_ones}), 32'(exp));
    chk({tag, "_zero"}, 32'(zero), 32'(m_sec == 0));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic load(input logic [3:0] mo, input logic [3:0] st, input logic [3:0] so);
    units_of_minutes = mo; tens_of_seconds = st; units_of_seconds = so;
    loadn = 1'b0;
    step("load");
    loadn = 1'b1;
  endtask

  function automatic logic [31:0] disp();
    return 32'({min_ones, sec_tens, sec_ones});
  endfunction

  int done_cnt;

  initial begin
    // 1. reset, then idle with enable low
    repeat (3) step("rst");
    chk("rst_digits", disp(), 32'h000);
    chk("rst_zero", 32'(zero), 32'd1);
    clearn = 1'b1;
    enablen = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step("idle");
      done_cnt += int'(done);
    end
    chk("idle_nodone", 32'(done_cnt), 32'd0);

    // 2. borrow chain 1:00 -> 0:59 -> 0:58
    load(4'd1, 4'd0, 4'd0);
    chk("t2_load", disp(), 32'h100);
    repeat (4) step("t2");
    chk("t2_059", disp(), 32'h059);
    repeat (4) step("t2");
    chk("t2_058", disp(), 32'h058);
    chk("t2_zero", 32'(zero), 32'd0);

    // 3. run to zero with single done pulse
    load(4'd0, 4'd0, 4'd2);
    repeat (4) step("t3");
    chk("t3_001", disp(), 32'h001);
    repeat (4) step("t3");
    chk("t3_000", disp(), 32'h000);
    chk("t3_done", 32'(done), 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step("t3_after");
      done_cnt += int'(done);
    end
    chk("t3_onepulse", 32'(done_cnt), 32'd0);

    // 4. pause preserves the fractional second
    load(4'd0, 4'd0, 4'd5);
    repeat (2) step("t4_run");
    enablen = 1'b1;
    repeat (10) step("t4_pause");
    chk("t4_hold", disp(), 32'h005);
    enablen = 1'b0;
    repeat (2) step("t4_resume");
    chk("t4_004", disp(), 32'h004);

    // 5. clamping and load priority over a due tick
    load(4'hF, 4'h7, 4'hC);
    chk("t5_clamp", disp(), 32'h959);
    repeat (3) step("t5_run");
    loadn = 1'b0;
    step("t5_tickload");
    chk("t5_nodec", disp(), 32'h959);
    for (int i = 0; i < 10; i++) step("t5_hold");
    chk("t5_held", disp(), 32'h959);
    loadn = 1'b1;

    // 6. async reset mid-count
    load(4'd3, 4'd2, 4'd7);
    repeat (10) step("t6_run");
    chk("t6_pre", disp(), 32'h325);
    #2;
    clearn = 1'b0;
    #1;
    model_reset();
    chk("t6_async_digits", disp(), 32'h000);
    chk("t6_async_zero", 32'(zero), 32'd1);
    clearn = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step("t6_after");
      done_cnt += int'(done);
    end
    chk("t6_nodone", 32'(done_cnt), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      loadn = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      enablen = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 1) == 0) begin
        units_of_seconds = 4'($urandom_range(0, 15));
        tens_of_seconds  = 4'($urandom_range(0, 15));
        units_of_minutes = 4'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 499) == 0) begin
        #2;
        clearn = 1'b0;
        #1;
        model_reset();
        chk("rnd_async", disp(), 32'h000);
        clearn = 1'b1;
      end
      step("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
